jtframe_ram_rr_arb: RTL

- Round-robin arbiter that shares one SDRAM controller port between four requesters (CPU, video, sound, DMA-type clients).
- Sits between the per-slot request logic and the SDRAM controller.
- Sequences each access through request, acknowledge and data phases.
- Returns read data and a one-cycle ok pulse to the winning slot.

---
 rtl/jtframe_ram_rr_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/jtframe_ram_rr_arb.sv
// Round-robin arbiter sharing one SDRAM controller port between four request slots.
// Define JTFRAME_ARB_PRIO0_EN to give slot 0 absolute priority over the rotating slots 1-3.
module jtframe_ram_rr_arb #(
    parameter int SDRAMW = 22,
    parameter int NS     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NS*SDRAMW-1:0] slot_addr,
    input  logic [NS-1:0]        slot_rd,
    input  logic [NS-1:0]        slot_wr,
    input  logic [NS*16-1:0]     slot_din,
    input  logic [NS*2-1:0]      slot_wrmask,
    output logic [NS-1:0]        slot_ok,
    output logic [31:0]          slot_dout,
    input  logic                 sdram_ack,
    input  logic                 data_rdy,
    input  logic [31:0]          data_read,
    output logic                 sdram_rd,
    output logic                 sdram_wr,
    output logic [SDRAMW-1:0]    sdram_addr,
    output logic [15:0]          data_write,
    output logic [1:0]           sdram_wrmask
);

    if (NS != 4) begin : g_bad_ns
        $error("jtframe_ram_rr_arb only supports NS=4");
    end

    typedef enum logic [1:0] { IDLE, CMD, DATA } state_t;

    state_t              state, state_nx;
    logic [1:0]          ptr, ptr_nx, grant, grant_nx, pick, idx;
    logic                is_wr, is_wr_nx, found, complete;
    logic [NS-1:0]       active, rr_req, ok_nx;
    logic                rd_nx, wr_nx;
    logic [SDRAMW-1:0]   addr_nx;
    logic [15:0]         dw_nx;
    logic [1:0]          mask_nx;
    logic [31:0]         dout_nx;

    // A slot whose ok is pulsing this cycle sits out one arbitration round.
    always_comb begin
        active = (slot_rd | slot_wr) & ~slot_ok;
        found  = |active;
`ifdef JTFRAME_ARB_PRIO0_EN
        rr_req = active & 4'b1110;
`else
        rr_req = active;
`endif
        pick = ptr;
        idx  = ptr;
        for (int i = NS-1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (rr_req[idx]) pick = idx;
        end
`ifdef JTFRAME_ARB_PRIO0_EN
        if (active[0]) pick = 2'd0;
`endif
    end

    always_comb begin
        // NOTE: every next-value defaults to the current register first, so no path infers a latch.
        state_nx = state;
        ptr_nx   = ptr;
        grant_nx = grant;
        is_wr_nx = is_wr;
        rd_nx    = sdram_rd;
        wr_nx    = sdram_wr;
        addr_nx  = sdram_addr;
        dw_nx    = data_write;
        mask_nx  = sdram_wrmask;
        dout_nx  = slot_dout;
        ok_nx    = '0;
        complete = 1'b0;
        case (state)
            IDLE: if (found) begin
                grant_nx = pick;
                is_wr_nx = slot_wr[pick];
                addr_nx  = slot_addr[int'(pick)*SDRAMW +: SDRAMW];
                dw_nx    = slot_din[int'(pick)*16 +: 16];
                mask_nx  = slot_wr[pick] ? slot_wrmask[int'(pick)*2 +: 2] : 2'b11;
                rd_nx    = ~slot_wr[pick];
                wr_nx    = slot_wr[pick];
                state_nx = CMD;
            end
            CMD: if (sdram_ack) begin
                rd_nx    = 1'b0;
                wr_nx    = 1'b0;
                state_nx = DATA;
                complete = data_rdy;
            end
            DATA:    complete = data_rdy;
            default: state_nx = IDLE;
        endcase
        if (complete) begin
            ok_nx = 4'b0001 << grant;
            if (!is_wr) dout_nx = data_read;
`ifdef JTFRAME_ARB_PRIO0_EN
            if (grant != 2'd0) ptr_nx = grant + 2'd1;
`else
            ptr_nx = grant + 2'd1;
`endif
            state_nx = IDLE;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            grant        <= '0;
            is_wr        <= 1'b0;
            sdram_rd     <= 1'b0;
            sdram_wr     <= 1'b0;
            sdram_addr   <= '0;
            data_write   <= '0;
            sdram_wrmask <= 2'b11;
            slot_dout    <= '0;
            slot_ok      <= '0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            grant        <= grant_nx;
            is_wr        <= is_wr_nx;
            sdram_rd     <= rd_nx;
            sdram_wr     <= wr_nx;
            sdram_addr   <= addr_nx;
            data_write   <= dw_nx;
            sdram_wrmask <= mask_nx;
            slot_dout    <= dout_nx;
            slot_ok      <= ok_nx;
        end
    end

endmodule
